envelope_pwm: RTL and testbench
===============================

Name: envelope_pwm

Overview:
- Downstream consumer of the pulse oscillator's 8-bit `data` output.
- Shapes the oscillator sample with a gate-driven ADSR amplitude envelope.
- Converts the scaled sample to a 1-bit PWM stream for the audio output pad.
- Sits between the oscillator and the chip output pin; the external RC filter reconstructs the audio.

Parameters:
- TICK_DIV, 256: clk cycles per envelope update tick (2..65536).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- gate  input  1  note on (1) / note off (0); level-sensitive, sampled on clk.
- osc_data  input  8  unsigned oscillator sample.
- attack_step  input  8  envelope increment per tick in ATTACK; 0 = instant.
- decay_step  input  8  envelope decrement per tick in DECAY; 0 = instant.
- sustain_level  input  8  SUSTAIN target level.
- release_step  input  8  envelope decrement per tick in RELEASE; 0 = instant.
- env_level  output  8  current envelope value (register).
- state  output  3  FSM state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active  output  1  state != IDLE.
- pwm_out  output  1  PWM audio bit.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, env_level=0, prescaler=0, pwm_cnt=0, duty=0, pwm_out=0.
  - Applies immediately, including mid-note or mid-PWM-period.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==TICK_DIV-1.
  - Free-running; never reset by gate.
- Priority rule:
  - FSM transitions caused by gate are evaluated every clk.
  - env_level changes only on tick cycles.
  - If a gate-caused transition and a tick occur in the same cycle, the transition wins and env_level is held that cycle.
- IDLE:
  - env_level=0.
  - gate=1 → ATTACK.
- ATTACK:
  - gate=0 → RELEASE.
  - On tick: env = min(env+attack_step, 255) (9-bit sum, saturating); attack_step=0 gives 255.
  - If the new env is 255 → DECAY on the same edge.
- DECAY:
  - gate=0 → RELEASE.
  - On tick: if env <= sustain_level, or env - sustain_level <= decay_step, or decay_step=0 → env=sustain_level and state → SUSTAIN; else env -= decay_step.
- SUSTAIN:
  - gate=0 → RELEASE.
  - On tick: env=sustain_level, so sustain changes take effect at the next tick.
- RELEASE:
  - gate=1 → ATTACK, keeping the current env (no restart from 0).
  - On tick: if env <= release_step or release_step=0 → env=0 and state → IDLE; else env -= release_step.
- Amplitude:
  - product = osc_data * env_level (16-bit unsigned).
  - scaled = product[15:8], truncated, no rounding.
- PWM counter and duty:
  - pwm_cnt counts 0..254; period is 255 clk.
  - In the cycle where pwm_cnt==254, duty <= scaled and pwm_cnt <= 0.
  - A new duty therefore applies from the next period start.
  - Mid-period changes in osc_data or env do not affect the current period.
- PWM output:
  - pwm_out = (pwm_cnt < duty), a compare of registers only; there is no combinational path from inputs.
  - duty=0 → constantly 0; duty=255 → constantly 1.
  - Latency from an env/osc_data change to the output is at most 255+1 clk.
- Widths: all arithmetic is unsigned; no intermediate value wraps.

Test Plan:
- Async reset: TICK_DIV=4, in SUSTAIN with env=100, drive rst_n=0 between clk edges → state=0, env_level=0, pwm_out=0, active=0 before the next edge; release reset, gate=0 → stays IDLE.
- Attack: TICK_DIV=4, attack_step=64, gate=1 → env_level 64,128,192,255 on successive ticks; state=2 (DECAY) on the 4th tick edge; attack_step=0 → 255 on the first tick.
- Decay/sustain: decay_step=50, sustain_level=100 from 255 → 205,155,105,100; state=3 at the tick producing 100; then sustain_level changed to 80 → env_level=80 at the next tick.
- Release with retrigger: from SUSTAIN env=100, release_step=30, gate=0 → state=4, env 70,40; gate=1 → state=1, then env 104 at the next tick (attack_step=64); gate=0 with release_step=0 → env=0, state=0 on the next tick.
- Priority: in ATTACK at env=128, drop gate in a tick cycle → state=4, env_level stays 128 that edge, then 98 at the next tick (release_step=30).
- PWM duty across two full 255-cycle periods each:
  - osc_data=0xFF, env=255 → duty=254, pwm_out high for 254 of 255 cycles.
  - osc_data=0xFF, env=128 → duty=127, high for 127 cycles.
  - osc_data=0x00 → pwm_out never high.
  - osc_data changed mid-period → duty changes only at the next period start.

Source files
------------

// File: rtl/envelope_pwm.sv
// envelope_pwm: gate-driven ADSR envelope that scales an oscillator sample,
// followed by a 255-clock PWM modulator feeding the audio output pad.
module envelope_pwm #(
    parameter int unsigned TICK_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gate,
    input  logic [7:0] osc_data,
    input  logic [7:0] attack_step,
    input  logic [7:0] decay_step,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_step,
    output logic [7:0] env_level,
    output logic [2:0] state,
    output logic       active,
    output logic       pwm_out
);

    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned ENV_W  = 8;
    localparam int unsigned SUM_W  = ENV_W + 1;
    localparam int unsigned PROD_W = 2 * ENV_W;

    localparam logic [ENV_W-1:0] ENV_MAX  = ENV_W'(255);
    localparam logic [ENV_W-1:0] PWM_LAST = ENV_W'(254);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ENV_W-1:0]   env_d;
    logic [PRE_W-1:0]   pre_q;
    logic               tick;
    logic [SUM_W-1:0]   att_sum;
    logic [ENV_W-1:0]   env_above_sus;
    logic [PROD_W-1:0]  product;
    logic [ENV_W-1:0]   scaled;
    logic [ENV_W-1:0]   pwm_cnt_q;
    logic [ENV_W-1:0]   pwm_cnt_d;
    logic [ENV_W-1:0]   duty_q;
    logic [ENV_W-1:0]   duty_d;

    assign tick          = (pre_q == PRE_W'(TICK_DIV - 1));
    assign att_sum       = SUM_W'(env_level) + SUM_W'(attack_step);
    assign env_above_sus = env_level - sustain_level;
    assign product       = PROD_W'(osc_data) * PROD_W'(env_level);
    assign scaled        = ENV_W'(product >> ENV_W);
    assign state         = state_q;

    // Free-running envelope tick prescaler, independent of gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Envelope state, level and activity registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            env_level <= '0;
            active    <= 1'b0;
        end else begin
            state_q   <= state_d;
            env_level <= env_d;
            active    <= (state_d != ST_IDLE);
        end
    end

    // Next state and level: gate transitions take precedence over tick updates
    always_comb begin
        state_d = state_q;
        env_d   = env_level;
        case (state_q)
            ST_IDLE: begin
                env_d = '0;
                if (gate) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if ((attack_step == '0) || (att_sum >= SUM_W'(ENV_MAX))) begin
                        env_d   = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = att_sum[ENV_W-1:0];
                    end
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if ((env_level <= sustain_level) || (env_above_sus <= decay_step) ||
                        (decay_step == '0)) begin
                        env_d   = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_level - decay_step;
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    env_d = sustain_level;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_d = ST_ATTACK;
                end else if (tick) begin
                    if ((env_level <= release_step) || (release_step == '0)) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_level - release_step;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = '0;
            end
        endcase
    end

    // PWM period counter; duty is latched only at the end of each period
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + ENV_W'(1);
        duty_d    = duty_q;
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = '0;
            duty_d    = scaled;
        end
    end

    // PWM registers; output registered from the same compare of counter and duty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_out   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out   <= (pwm_cnt_d < duty_d);
        end
    end

endmodule

// File: tb/tb_envelope_pwm.sv
// Bench for envelope_pwm: directed ADSR/PWM scenarios plus randomized
// stimulus, all cross-checked every cycle against a behavioural model.
module tb_envelope_pwm;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       gate = 1'b0;
    logic [7:0] osc_data = 8'd0;
    logic [7:0] attack_step = 8'd0;
    logic [7:0] decay_step = 8'd0;
    logic [7:0] sustain_level = 8'd0;
    logic [7:0] release_step = 8'd0;
    logic [7:0] env_level;
    logic [2:0] state;
    logic       active;
    logic       pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference state (values after the most recent clock edge)
    int m_state = 0;
    int m_env = 0;
    int m_pre = 0;
    int m_cnt = 0;
    int m_duty = 0;
    bit m_pwm = 1'b0;
    bit m_ticked = 1'b0;

    envelope_pwm #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .osc_data     (osc_data),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_level(sustain_level),
        .release_step (release_step),
        .env_level    (env_level),
        .state        (state),
        .active       (active),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: async reset
    always @(negedge rst_n) begin
        m_state = 0; m_env = 0; m_pre = 0; m_cnt = 0; m_duty = 0;
        m_pwm = 1'b0; m_ticked = 1'b0;
    end

    // Reference model: ADSR rules and PWM period behaviour in plain arithmetic
    always @(posedge clk) begin
        int ns, ne, scaled, a, d, s, r;
        bit tk;
        if (rst_n) begin
            a = int'(attack_step); d = int'(decay_step);
            s = int'(sustain_level); r = int'(release_step);
            tk = (m_pre == TICK_DIV - 1);
            scaled = (int'(osc_data) * m_env) / 256;
            ns = m_state; ne = m_env;
            case (m_state)
                0: if (gate) ns = 1;
                1: if (!gate) ns = 4;
                   else if (tk) begin
                       ne = (a == 0) ? 255 : m_env + a;
                       if (ne > 255) ne = 255;
                       if (ne == 255) ns = 2;
                   end
                2: if (!gate) ns = 4;
                   else if (tk) begin
                       if (m_env <= s || (m_env - s) <= d || d == 0) begin ne = s; ns = 3; end
                       else ne = m_env - d;
                   end
                3: if (!gate) ns = 4;
                   else if (tk) ne = s;
                4: if (gate) ns = 1;
                   else if (tk) begin
                       if (m_env <= r || r == 0) begin ne = 0; ns = 0; end
                       else ne = m_env - r;
                   end
                default: ns = 0;
            endcase
            if (m_cnt == 254) begin m_cnt = 0; m_duty = scaled; end
            else m_cnt = m_cnt + 1;
            m_pwm = (m_cnt < m_duty);
            m_ticked = tk;
            m_pre = tk ? 0 : m_pre + 1;
            m_state = ns;
            m_env = ne;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check_val("cyc_state", 16'(state), 16'(m_state));
        check_val("cyc_env", 16'(env_level), 16'(m_env));
        check_val("cyc_active", 16'(active), 16'(m_state != 0));
        check_val("cyc_pwm", 16'(pwm_out), 16'(m_pwm));
    end

    // Advance to the first negedge following a tick edge
    task automatic wait_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (!m_ticked && n < 4 * TICK_DIV);
    endtask

    // Count pwm_out highs over one full period starting at pwm_cnt==0
    task automatic measure_period(output int highs);
        int n = 0;
        highs = 0;
        while (m_cnt != 0 && n < 300) begin @(negedge clk); n++; end
        for (int i = 0; i < 255; i++) begin
            highs += int'(pwm_out);
            @(negedge clk);
        end
    endtask

    initial begin
        int highs;
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_state", 16'(state), 16'd0);
        check_val("rst_env", 16'(env_level), 16'd0);
        check_val("rst_active", 16'(active), 16'd0);
        check_val("rst_pwm", 16'(pwm_out), 16'd0);

        // Attack 64 per tick, then decay 50 down to sustain 100
        rst_n = 1'b1;
        attack_step = 8'd64; decay_step = 8'd50; sustain_level = 8'd100;
        release_step = 8'd30; osc_data = 8'h80;
        @(negedge clk); gate = 1'b1;
        @(negedge clk); check_val("atk_enter", 16'(state), 16'd1);
        wait_tick(); check_val("atk_64", 16'(env_level), 16'd64);
        wait_tick(); check_val("atk_128", 16'(env_level), 16'd128);
        wait_tick(); check_val("atk_192", 16'(env_level), 16'd192);
        check_val("atk_state", 16'(state), 16'd1);
        wait_tick(); check_val("atk_255", 16'(env_level), 16'd255);
        check_val("atk_to_decay", 16'(state), 16'd2);
        wait_tick(); check_val("dec_205", 16'(env_level), 16'd205);
        wait_tick(); check_val("dec_155", 16'(env_level), 16'd155);
        wait_tick(); check_val("dec_105", 16'(env_level), 16'd105);
        check_val("dec_state", 16'(state), 16'd2);
        wait_tick(); check_val("dec_100", 16'(env_level), 16'd100);
        check_val("dec_to_sus", 16'(state), 16'd3);
        sustain_level = 8'd80;
        wait_tick(); check_val("sus_80", 16'(env_level), 16'd80);
        sustain_level = 8'd100;
        wait_tick(); check_val("sus_100", 16'(env_level), 16'd100);

        // Release with retrigger
        gate = 1'b0;
        @(negedge clk); check_val("rel_enter", 16'(state), 16'd4);
        check_val("rel_hold", 16'(env_level), 16'd100);
        wait_tick(); check_val("rel_70", 16'(env_level), 16'd70);
        wait_tick(); check_val("rel_40", 16'(env_level), 16'd40);
        gate = 1'b1;
        @(negedge clk); check_val("retrig_state", 16'(state), 16'd1);
        wait_tick(); check_val("retrig_104", 16'(env_level), 16'd104);
        gate = 1'b0; release_step = 8'd0;
        @(negedge clk); check_val("rel0_state", 16'(state), 16'd4);
        wait_tick(); check_val("rel0_env", 16'(env_level), 16'd0);
        check_val("rel0_idle", 16'(state), 16'd0);
        check_val("rel0_active", 16'(active), 16'd0);

        // Instant attack, then settle to sustain 100
        attack_step = 8'd0;
        gate = 1'b1;
        @(negedge clk);
        wait_tick(); check_val("atk0_255", 16'(env_level), 16'd255);
        check_val("atk0_state", 16'(state), 16'd2);
        n = 0;
        while (state != 3'd3 && n < 100) begin @(negedge clk); n++; end
        check_val("sus_reached", 16'(state), 16'd3);
        check_val("sus_env", 16'(env_level), 16'd100);

        // Async reset between edges
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check_val("arst_state", 16'(state), 16'd0);
        check_val("arst_env", 16'(env_level), 16'd0);
        check_val("arst_pwm", 16'(pwm_out), 16'd0);
        check_val("arst_active", 16'(active), 16'd0);
        gate = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("arst_idle", 16'(state), 16'd0);

        // Gate drop in a tick cycle: transition wins, env held
        attack_step = 8'd64; release_step = 8'd30;
        gate = 1'b1;
        @(negedge clk);
        wait_tick(); wait_tick();
        check_val("pri_128", 16'(env_level), 16'd128);
        n = 0;
        while (m_pre != TICK_DIV - 1 && n < 2 * TICK_DIV) begin @(negedge clk); n++; end
        gate = 1'b0;
        @(negedge clk);
        check_val("pri_state", 16'(state), 16'd4);
        check_val("pri_hold", 16'(env_level), 16'd128);
        wait_tick(); check_val("pri_98", 16'(env_level), 16'd98);
        release_step = 8'd0;
        wait_tick(); check_val("pri_idle", 16'(state), 16'd0);

        // PWM: full-scale sample at env 255
        attack_step = 8'd0; decay_step = 8'd0; sustain_level = 8'd255;
        osc_data = 8'hFF; gate = 1'b1;
        repeat (600) @(negedge clk);
        check_val("pwm_env255", 16'(env_level), 16'd255);
        measure_period(highs); check_val("pwm_254_a", 16'(highs), 16'd254);
        measure_period(highs); check_val("pwm_254_b", 16'(highs), 16'd254);

        // PWM at env 128
        sustain_level = 8'd128;
        repeat (600) @(negedge clk);
        check_val("pwm_env128", 16'(env_level), 16'd128);
        measure_period(highs); check_val("pwm_127_a", 16'(highs), 16'd127);
        measure_period(highs); check_val("pwm_127_b", 16'(highs), 16'd127);

        // PWM with zero sample
        osc_data = 8'h00;
        repeat (600) @(negedge clk);
        measure_period(highs); check_val("pwm_0_a", 16'(highs), 16'd0);
        measure_period(highs); check_val("pwm_0_b", 16'(highs), 16'd0);

        // Mid-period sample change only takes effect at the next period
        n = 0;
        while (m_cnt != 0 && n < 300) begin @(negedge clk); n++; end
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 100) osc_data = 8'hFF;
            highs += int'(pwm_out);
            @(negedge clk);
        end
        check_val("pwm_mid_old", 16'(highs), 16'd0);
        measure_period(highs); check_val("pwm_mid_new", 16'(highs), 16'd127);

        // Randomized stimulus against the model
        for (int it = 0; it < 80; it++) begin
            gate = 1'($urandom_range(0, 1));
            attack_step   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            decay_step    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            release_step  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            sustain_level = 8'($urandom);
            osc_data      = 8'($urandom);
            if ($urandom_range(0, 14) == 0) begin
                @(posedge clk); #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        repeat (600) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
